// File: rtl/icache_dm_word.sv
// icache_dm_word: direct-mapped, read-only instruction cache with one-word lines.
// It sits between the fetch stage's request port and the instruction port of
// the AXI bridge. Hits return data one cycle after the request is accepted.
// Misses fetch a single word from the bridge, refill the line and forward the
// word to the CPU in the same cycle it arrives.
// Tag and data arrays are read synchronously: the index is taken on accept and
// the array outputs are consumed in LOOKUP, so the arrays can map to block RAM.
module icache_dm_word #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_cpu_req,
  input  logic [31:0] i_cpu_addr,
  output logic        o_cpu_addr_ok,
  output logic        o_cpu_data_ok,
  output logic [31:0] o_cpu_rdata,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_addr_ok,
  input  logic        i_mem_data_ok,
  input  logic [31:0] i_mem_rdata
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_MISS   = 2'd2,
    ST_REFILL = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Word address of the outstanding request (byte offset is never needed).
  logic [29:0]      r_req_word;
  logic [LINES-1:0] r_valid;
  logic             r_flush_pend;

  // Storage arrays, intentionally without reset.
  logic [TAG_W-1:0] r_tag_mem  [LINES];
  logic [31:0]      r_data_mem [LINES];

  // Synchronous-read outputs of the arrays, consumed in LOOKUP.
  logic [TAG_W-1:0] r_tag_rd;
  logic [31:0]      r_data_rd;

  logic             w_accept;
  logic [IDX_W-1:0] w_acc_idx;
  logic [IDX_W-1:0] w_req_idx;
  logic [TAG_W-1:0] w_req_tag;
  logic             w_hit;
  logic             w_refill_we;
  logic             w_in_miss_path;
  logic             w_unused;

  // Address field extraction for the incoming and the outstanding request.
  assign w_acc_idx = i_cpu_addr[IDX_W+1:2];
  assign w_req_idx = r_req_word[IDX_W-1:0];
  assign w_req_tag = r_req_word[29:IDX_W];

  // Byte offset of the fetch address has no meaning for word fetches.
  assign w_unused = ^i_cpu_addr[1:0];

  // A flush in LOOKUP forces a miss so stale contents are never returned.
  assign w_hit = (r_state == ST_LOOKUP) & r_valid[w_req_idx] &
                 (r_tag_rd == w_req_tag) & ~i_flush;

  assign w_accept       = i_cpu_req & o_cpu_addr_ok;
  assign w_refill_we    = (r_state == ST_REFILL) & i_mem_data_ok;
  assign w_in_miss_path = (r_state == ST_MISS) | (r_state == ST_REFILL);

  // The miss address is always the word-aligned request address.
  assign o_mem_addr = {r_req_word, 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake outputs; hit data and refill bypass are combinational.
  always_comb begin
    w_next_state  = r_state;
    o_cpu_addr_ok = 1'b0;
    o_cpu_data_ok = 1'b0;
    o_cpu_rdata   = r_data_rd;
    o_mem_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cpu_addr_ok = 1'b1;
        if (i_cpu_req) begin
          w_next_state = ST_LOOKUP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          o_cpu_data_ok = 1'b1;
          o_cpu_rdata   = r_data_rd;
          // Accepting on the hit cycle keeps back-to-back hits at one per cycle.
          o_cpu_addr_ok = 1'b1;
          if (i_cpu_req) begin
            w_next_state = ST_LOOKUP;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_MISS;
        end
      end
      ST_MISS: begin
        o_mem_req = 1'b1;
        if (i_mem_addr_ok) begin
          w_next_state = ST_REFILL;
        end else begin
          w_next_state = ST_MISS;
        end
      end
      ST_REFILL: begin
        if (i_mem_data_ok) begin
          o_cpu_data_ok = 1'b1;
          o_cpu_rdata   = i_mem_rdata;
          w_next_state  = ST_IDLE;
        end else begin
          w_next_state  = ST_REFILL;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Capture the word address of each accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_word <= 30'd0;
    end else if (w_accept) begin
      r_req_word <= i_cpu_addr[31:2];
    end
  end

  // Launch the synchronous array read at the index of the accepted request.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag_rd  <= r_tag_mem[w_acc_idx];
      r_data_rd <= r_data_mem[w_acc_idx];
    end
  end

  // Refill writes tag and data; the line may still stay invalid after a flush.
  always_ff @(posedge clk) begin
    if (w_refill_we) begin
      r_tag_mem[w_req_idx]  <= w_req_tag;
      r_data_mem[w_req_idx] <= i_mem_rdata;
    end
  end

  // Valid bits: flush wipes everything in one cycle, a clean refill sets one line.
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= {LINES{1'b0}};
    end else if (w_refill_we && !r_flush_pend) begin
      r_valid[w_req_idx] <= 1'b1;
    end
  end

  // Remember a flush that arrived while a refill was in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flush_pend <= 1'b0;
    end else if (w_refill_we) begin
      r_flush_pend <= 1'b0;
    end else if (i_flush && w_in_miss_path) begin
      r_flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_dm_word.sv
// Directed, table-driven bench for icache_dm_word. Each table record describes
// one fetch: address, whether it must miss, the expected bridge address, the
// word (returned by the bridge model on a miss, expected by the CPU in either
// case), bridge handshake delays and where a flush pulse is placed.
// Inputs change on the falling edge and outputs are sampled 1 ns later.
module tb_icache_dm_word;

  localparam int FL_NONE   = 0;
  localparam int FL_LOOKUP = 1;
  localparam int FL_REFILL = 2;
  localparam int FL_IDLE   = 3;
  localparam int NV        = 22;
  localparam int SPLIT     = 14;

  typedef struct {
    logic [31:0] addr;
    logic        miss;
    logic [31:0] maddr;
    logic [31:0] data;
    int          aok;
    int          dok;
    int          fl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [NV];

  icache_dm_word #(.IDX_W(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_flush       (flush),
    .i_cpu_req     (cpu_req),
    .i_cpu_addr    (cpu_addr),
    .o_cpu_addr_ok (cpu_addr_ok),
    .o_cpu_data_ok (cpu_data_ok),
    .o_cpu_rdata   (cpu_rdata),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_addr_ok (mem_addr_ok),
    .i_mem_data_ok (mem_data_ok),
    .i_mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete fetch from an idle cache, acting as the bridge on a miss.
  task automatic run_vec(input vec_t v, input string nm);
    if (v.fl == FL_IDLE) begin
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk({nm, ".idle_flush_data_ok"}, {31'd0, cpu_data_ok}, 32'd0);
    end
    @(negedge clk);
    flush    = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = v.addr;
    #1;
    chk({nm, ".accept"}, {31'd0, cpu_addr_ok}, 32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
    flush   = (v.fl == FL_LOOKUP);
    #1;
    if (!v.miss) begin
      chk({nm, ".hit_data_ok"}, {31'd0, cpu_data_ok}, 32'd1);
      chk({nm, ".hit_rdata"}, cpu_rdata, v.data);
      chk({nm, ".hit_mem_req"}, {31'd0, mem_req}, 32'd0);
    end else begin
      chk({nm, ".lookup_data_ok"}, {31'd0, cpu_data_ok}, 32'd0);
      chk({nm, ".lookup_addr_ok"}, {31'd0, cpu_addr_ok}, 32'd0);
      for (int k = 0; k <= v.aok; k++) begin
        @(negedge clk);
        flush       = 1'b0;
        mem_addr_ok = (k == v.aok);
        #1;
        chk({nm, ".miss_mem_req"}, {31'd0, mem_req}, 32'd1);
        chk({nm, ".miss_mem_addr"}, mem_addr, v.maddr);
        chk({nm, ".miss_data_ok"}, {31'd0, cpu_data_ok}, 32'd0);
        chk({nm, ".miss_addr_ok"}, {31'd0, cpu_addr_ok}, 32'd0);
      end
      for (int k = 0; k <= v.dok; k++) begin
        @(negedge clk);
        mem_addr_ok = 1'b0;
        mem_data_ok = (k == v.dok);
        mem_rdata   = (k == v.dok) ? v.data : 32'h0BAD_0BAD;
        flush       = (v.fl == FL_REFILL) && (k == 0);
        #1;
        chk({nm, ".refill_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({nm, ".refill_addr_ok"}, {31'd0, cpu_addr_ok}, 32'd0);
        chk({nm, ".refill_data_ok"}, {31'd0, cpu_data_ok}, {31'd0, (k == v.dok)});
        if (k == v.dok) begin
          chk({nm, ".refill_rdata"}, cpu_rdata, v.data);
        end
      end
    end
    @(negedge clk);
    flush       = 1'b0;
    mem_data_ok = 1'b0;
    mem_addr_ok = 1'b0;
    #1;
    chk({nm, ".done_data_ok"}, {31'd0, cpu_data_ok}, 32'd0);
    chk({nm, ".done_addr_ok"}, {31'd0, cpu_addr_ok}, 32'd1);
    chk({nm, ".done_mem_req"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    //            addr          miss  maddr         data          aok dok flush
    vecs[0]  = '{32'h1FC0_0000, 1'b1, 32'h1FC0_0000, 32'hDEAD_BEEF, 2, 3, FL_NONE};
    vecs[1]  = '{32'h1FC0_0000, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, FL_NONE};
    vecs[2]  = '{32'h1FC0_0003, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, FL_NONE};
    vecs[3]  = '{32'h0000_0040, 1'b1, 32'h0000_0040, 32'h1111_0040, 0, 0, FL_NONE};
    vecs[4]  = '{32'h0000_0140, 1'b1, 32'h0000_0140, 32'h2222_0140, 1, 1, FL_NONE};
    vecs[5]  = '{32'h0000_0040, 1'b1, 32'h0000_0040, 32'h3333_0040, 0, 2, FL_NONE};
    vecs[6]  = '{32'h0000_0040, 1'b0, 32'h0000_0000, 32'h3333_0040, 0, 0, FL_NONE};
    vecs[7]  = '{32'h1FC0_0000, 1'b0, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, FL_NONE};
    vecs[8]  = '{32'h0000_2007, 1'b1, 32'h0000_2004, 32'h4444_2004, 1, 0, FL_NONE};
    vecs[9]  = '{32'h0000_2004, 1'b0, 32'h0000_0000, 32'h4444_2004, 0, 0, FL_NONE};
    vecs[10] = '{32'h0000_1000, 1'b1, 32'h0000_1000, 32'hA000_1000, 0, 0, FL_NONE};
    vecs[11] = '{32'h0000_1004, 1'b1, 32'h0000_1004, 32'hA000_1004, 1, 0, FL_NONE};
    vecs[12] = '{32'h0000_1008, 1'b1, 32'h0000_1008, 32'hA000_1008, 0, 1, FL_NONE};
    vecs[13] = '{32'h0000_100C, 1'b1, 32'h0000_100C, 32'hA000_100C, 2, 2, FL_NONE};
    vecs[14] = '{32'h0000_2000, 1'b1, 32'h0000_2000, 32'h5555_2000, 1, 1, FL_NONE};
    vecs[15] = '{32'h0000_2000, 1'b1, 32'h0000_2000, 32'h6666_2000, 0, 1, FL_IDLE};
    vecs[16] = '{32'h0000_2000, 1'b0, 32'h0000_0000, 32'h6666_2000, 0, 0, FL_NONE};
    vecs[17] = '{32'h0000_3000, 1'b1, 32'h0000_3000, 32'h7777_3000, 1, 2, FL_REFILL};
    vecs[18] = '{32'h0000_3000, 1'b1, 32'h0000_3000, 32'h8888_3000, 0, 0, FL_NONE};
    vecs[19] = '{32'h0000_3000, 1'b0, 32'h0000_0000, 32'h8888_3000, 0, 0, FL_NONE};
    vecs[20] = '{32'h0000_3000, 1'b1, 32'h0000_3000, 32'h9999_3000, 0, 0, FL_LOOKUP};
    vecs[21] = '{32'h0000_3000, 1'b0, 32'h0000_0000, 32'h9999_3000, 0, 0, FL_NONE};

    reset       = 1'b1;
    flush       = 1'b0;
    cpu_req     = 1'b0;
    cpu_addr    = 32'd0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset.addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    chk("reset.data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("reset.mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < SPLIT; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Streaming hits over the preloaded 0x1000..0x100C, one request per cycle.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_1000;
    #1;
    chk("stream.first_accept", {31'd0, cpu_addr_ok}, 32'd1);
    chk("stream.first_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k < 4) begin
        cpu_addr = 32'h0000_1000 + 32'(4 * k);
      end else begin
        cpu_req = 1'b0;
      end
      #1;
      chk($sformatf("stream%0d.data_ok", k), {31'd0, cpu_data_ok}, 32'd1);
      chk($sformatf("stream%0d.rdata", k), cpu_rdata, 32'hA000_1000 + 32'(4 * (k - 1)));
      chk($sformatf("stream%0d.addr_ok", k), {31'd0, cpu_addr_ok}, 32'd1);
      chk($sformatf("stream%0d.mem_req", k), {31'd0, mem_req}, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("stream.end_data_ok", {31'd0, cpu_data_ok}, 32'd0);

    for (int i = SPLIT; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset while a miss waits for mem_addr_ok, then a stray bridge response.
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h0000_4000;
    #1;
    chk("rst_miss.accept", {31'd0, cpu_addr_ok}, 32'd1);
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    chk("rst_miss.lookup_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_miss.mem_req", {31'd0, mem_req}, 32'd1);
    chk("rst_miss.mem_addr", mem_addr, 32'h0000_4000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_miss.after_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_miss.after_addr_ok", {31'd0, cpu_addr_ok}, 32'd1);
    chk("rst_miss.after_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b1;
    mem_rdata   = 32'hBADB_AD00;
    #1;
    chk("stray.data_ok", {31'd0, cpu_data_ok}, 32'd0);
    @(negedge clk);
    mem_data_ok = 1'b0;
    #1;
    chk("stray.after_data_ok", {31'd0, cpu_data_ok}, 32'd0);
    chk("stray.after_mem_req", {31'd0, mem_req}, 32'd0);

    // Lines valid before the reset must now miss; the aborted line too.
    run_vec('{32'h0000_3000, 1'b1, 32'h0000_3000, 32'h1234_3000, 0, 1, FL_NONE}, "post_rst_3000");
    run_vec('{32'h0000_1004, 1'b1, 32'h0000_1004, 32'h1234_1004, 1, 0, FL_NONE}, "post_rst_1004");
    run_vec('{32'h0000_4000, 1'b1, 32'h0000_4000, 32'h1234_4000, 0, 0, FL_NONE}, "post_rst_4000");
    run_vec('{32'h0000_4000, 1'b0, 32'h0000_0000, 32'h1234_4000, 0, 0, FL_NONE}, "post_rst_4000_hit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_dm_word.md
Name: icache_dm_word

Overview:
- Direct-mapped, read-only instruction cache with one-word lines.
- Sits between the fetch stage's SRAM-like request port and the instruction SRAM-like port of the AXI bridge.
- Hits return data one cycle after the request is accepted. Misses issue a single-word read to the bridge, refill the line, and forward the data to the CPU.
- Provides whole-cache invalidate for fence/self-modifying code.

Parameters:
IDX_W, 6, index width; number of lines = 2^IDX_W (default 64 lines, 256 B)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  invalidate all lines (single-cycle pulse or level)
cpu_req  input  1  fetch request valid
cpu_addr  input  32  fetch address; bits [1:0] ignored
cpu_addr_ok  output  1  request accepted this cycle (when cpu_req=1)
cpu_data_ok  output  1  read data valid, one pulse per accepted request
cpu_rdata  output  32  read data, valid while cpu_data_ok=1
mem_req  output  1  miss request to bridge inst port
mem_addr  output  32  miss address, word-aligned {addr[31:2],2'b00}
mem_addr_ok  input  1  bridge accepted mem_req
mem_data_ok  input  1  bridge returned data
mem_rdata  input  32  bridge read data

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE; all valid bits=0.
  - cpu_addr_ok=1, cpu_data_ok=0, mem_req=0.
  - mem_addr and cpu_rdata are don't-care.
  - Tag and data arrays are not reset.
- Address fields:
  - index = addr[IDX_W+1:2]
  - tag = addr[31:IDX_W+2], width 30-IDX_W
- Storage:
  - Valid bits are flops, cleared in one cycle by flush.
  - Tag and data arrays use synchronous read: index registered on accept, outputs used in LOOKUP. They must map to block RAM or flop arrays.
- Accept: a request is accepted on cycle N when cpu_req & cpu_addr_ok. On accept, latch addr into req_addr and launch the array read.
- At most one request is outstanding. cpu_data_ok is returned in request order.
- FSM:
  - IDLE: cpu_addr_ok=1. On accept -> LOOKUP.
  - LOOKUP: hit = valid[idx] & (tag_rd == req_tag) & ~flush.
    - On hit: cpu_data_ok=1 and cpu_rdata=data_rd. cpu_addr_ok=1 the same cycle, so back-to-back hits sustain 1 word/cycle. If a new request is accepted, stay in LOOKUP; otherwise go to IDLE.
    - On miss: cpu_addr_ok=0 -> MISS.
  - MISS: mem_req=1, mem_addr={req_addr[31:2],2'b00}, held stable until mem_addr_ok. On mem_req & mem_addr_ok -> REFILL; mem_req drops the next cycle. cpu_addr_ok=0.
  - REFILL: cpu_addr_ok=0. Wait for mem_data_ok. On mem_data_ok:
    - write data array[idx]=mem_rdata and tag array[idx]=req_tag;
    - set valid[idx]=1 unless flush was seen during MISS/REFILL;
    - cpu_data_ok=1, cpu_rdata=mem_rdata (combinational bypass);
    - -> IDLE.
- Latency:
  - hit: cpu_data_ok 1 cycle after accept.
  - miss: cpu_data_ok = 1 (LOOKUP) + MISS cycles until mem_addr_ok + bridge latency; data is forwarded in the same cycle as mem_data_ok.
- Flush:
  - Clears all valid bits on the cycle it is sampled.
  - In LOOKUP it forces a miss.
  - During MISS/REFILL it sets a flush_pend flag. The pending refill completes and returns data to the CPU but leaves the line invalid. flush_pend clears on the REFILL->IDLE transition.
  - Flush in IDLE only clears valid bits.
- mem_data_ok outside REFILL is ignored. This covers a bridge response for a transaction orphaned by reset.
- Reset mid-miss: returns to IDLE immediately; mem_req deasserts the cycle after reset. No cpu_data_ok is produced for the aborted request.
- mem_addr_ok and mem_data_ok in the same cycle while in MISS are illegal (bridge guarantees ≥1 cycle between them); behaviour is unspecified.
- Index wrap: addresses differing only in tag alias to one line; a later refill overwrites the earlier one.

Test Plan:
- Cold miss: reset, fetch 0x1FC0_0000; bridge gives mem_addr_ok after 2 cycles and mem_data_ok=0xDEADBEEF after 3 more -> mem_addr=0x1FC0_0000, one cpu_data_ok with 0xDEADBEEF; a refetch hits with cpu_data_ok 1 cycle after accept, no mem_req.
- Streaming hits: preload 0x1000..0x100C, then issue cpu_req every cycle -> cpu_addr_ok held 1, cpu_data_ok on 4 consecutive cycles with the correct words, mem_req stays 0.
- Conflict: IDX_W=6, fetch 0x0000_0040 then 0x0000_0140 (same index, different tag), then 0x0000_0040 again -> three misses, with mem_addr matching each address.
- Flush: fill 0x2000, pulse flush, refetch 0x2000 -> miss. Pulse flush during REFILL of 0x3000 -> data still returned, and the next fetch of 0x3000 misses again.
- Reset during MISS with mem_addr_ok pending: assert reset -> mem_req=0 next cycle, state IDLE. A later stray mem_data_ok yields no cpu_data_ok and leaves valid bits at 0.
- Unaligned address 0x1FC0_0003 -> mem_addr=0x1FC0_0000, and it hits the same line as 0x1FC0_0000.
